// File: rtl/smc_ahb_fill_master.sv
// smc_ahb_fill_master: AHB-Lite initiator that fills or
// read-compares a word region of SMC SRAM.
module smc_ahb_fill_master #(
  parameter int         LEN_W       = 16,
  parameter logic [3:0] HPROT_VAL   = 4'b0011,
  parameter int         BOUND_BYTES = 1024
) (
  input  logic             pmu_smc_hclk,
  input  logic             pmu_smc_hrst_b,
  input  logic             cmd_start,
  input  logic             cmd_write,
  input  logic             cmd_incr,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      cmd_pattern,
  output logic             cmd_busy,
  output logic             cmd_done,
  output logic             cmd_err,
  output logic [LEN_W-1:0] cmd_mis_cnt,
  output logic [31:0]      cmd_mis_addr,
  output logic             sfm_smc_hsel,
  output logic [31:0]      sfm_smc_haddr,
  output logic [1:0]       sfm_smc_htrans,
  output logic             sfm_smc_hwrite,
  output logic [2:0]       sfm_smc_hsize,
  output logic [3:0]       sfm_smc_hprot,
  output logic [31:0]      sfm_smc_hwdata,
  input  logic [31:0]      smc_sfm_hrdata,
  input  logic             smc_sfm_hready,
  input  logic [1:0]       smc_sfm_hresp
);

  localparam int BW = $clog2(BOUND_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DRAIN, S_ERR, S_DONE
  } state_t;

  state_t state, nxt;

  logic             wr_q, incr_q;
  logic [LEN_W-1:0] len_q, acnt, mis_cnt;
  logic [31:0]      pat_q, aaddr, daddr, exp_q, mis_addr;
  logic             dp_vld, err_q;
  logic             hready, err_resp, dp_done, acc, last, bound;

  assign hready   = smc_sfm_hready;
  assign err_resp = (smc_sfm_hresp == 2'b01);
  assign dp_done  = dp_vld & hready & ~err_resp;
  assign acc      = (state == S_ADDR) & hready
                  & ~(dp_vld & err_resp);
  assign last     = (acnt == len_q - LEN_W'(1));
  assign bound    = (aaddr[BW-1:0] == '0);

  always_ff @(posedge pmu_smc_hclk or negedge pmu_smc_hrst_b) begin
    if (!pmu_smc_hrst_b) state <= S_IDLE;
    else                 state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (cmd_start)
          nxt = (cmd_len == '0) ? S_DONE : S_ADDR;
      end
      S_ADDR: begin
        if (dp_vld && err_resp)
          nxt = hready ? S_DONE : S_ERR;
        else if (acc && last)
          nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (err_resp)
          nxt = hready ? S_DONE : S_ERR;
        else if (hready)
          nxt = S_DONE;
      end
      S_ERR: begin
        if (hready) nxt = S_DONE;
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pmu_smc_hclk or negedge pmu_smc_hrst_b) begin
    if (!pmu_smc_hrst_b) begin
      wr_q     <= 1'b0;
      incr_q   <= 1'b0;
      len_q    <= '0;
      pat_q    <= '0;
      acnt     <= '0;
      aaddr    <= '0;
      daddr    <= '0;
      exp_q    <= '0;
      dp_vld   <= 1'b0;
      err_q    <= 1'b0;
      mis_cnt  <= '0;
      mis_addr <= '0;
    end else begin
      if (state == S_IDLE && cmd_start) begin
        wr_q     <= cmd_write;
        incr_q   <= cmd_incr;
        len_q    <= cmd_len;
        pat_q    <= cmd_pattern;
        aaddr    <= {cmd_addr[31:2], 2'b00};
        acnt     <= '0;
        dp_vld   <= 1'b0;
        err_q    <= 1'b0;
        mis_cnt  <= '0;
        mis_addr <= '0;
      end
      if (acc) begin
        dp_vld <= 1'b1;
        daddr  <= aaddr;
        exp_q  <= pat_q + (incr_q ? 32'(acnt) : 32'd0);
        acnt   <= acnt + LEN_W'(1);
        aaddr  <= aaddr + 32'd4;
      end else if (hready) begin
        dp_vld <= 1'b0;
      end
      // two-cycle ERROR: the pending address phase is dropped
      if (nxt == S_ERR) dp_vld <= 1'b0;
      if (hready && ((dp_vld && err_resp) || state == S_ERR))
        err_q <= 1'b1;
      if (dp_done && !wr_q && smc_sfm_hrdata != exp_q) begin
        if (mis_cnt != '1) mis_cnt <= mis_cnt + LEN_W'(1);
        if (mis_cnt == '0) mis_addr <= daddr;
      end
    end
  end

  assign cmd_busy       = (state != S_IDLE);
  assign cmd_done       = (state == S_DONE);
  assign cmd_err        = err_q;
  assign cmd_mis_cnt    = mis_cnt;
  assign cmd_mis_addr   = mis_addr;
  assign sfm_smc_hsel   = cmd_busy;
  assign sfm_smc_haddr  = aaddr;
  assign sfm_smc_htrans = (state != S_ADDR) ? 2'b00 :
                          (acnt == '0 || bound) ? 2'b10 : 2'b11;
  assign sfm_smc_hwrite = cmd_busy & wr_q;
  assign sfm_smc_hsize  = 3'b010;
  assign sfm_smc_hprot  = HPROT_VAL;
  assign sfm_smc_hwdata = exp_q;

endmodule

// File: tb/tb_smc_ahb_fill_master.sv
// tb_smc_ahb_fill_master: directed commands, AHB slave model
// and scoreboard monitor for smc_ahb_fill_master.
module tb_smc_ahb_fill_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_start = 1'b0;
  logic        cmd_write = 1'b0;
  logic        cmd_incr = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [15:0] cmd_len = '0;
  logic [31:0] cmd_pattern = '0;
  logic        cmd_busy, cmd_done, cmd_err;
  logic [15:0] cmd_mis_cnt;
  logic [31:0] cmd_mis_addr;
  logic        hsel, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [31:0] hrdata = '0;
  logic        hready = 1'b1;
  logic [1:0]  hresp = 2'b00;

  smc_ahb_fill_master dut (
    .pmu_smc_hclk   (clk),
    .pmu_smc_hrst_b (rst_n),
    .cmd_start      (cmd_start),
    .cmd_write      (cmd_write),
    .cmd_incr       (cmd_incr),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .cmd_pattern    (cmd_pattern),
    .cmd_busy       (cmd_busy),
    .cmd_done       (cmd_done),
    .cmd_err        (cmd_err),
    .cmd_mis_cnt    (cmd_mis_cnt),
    .cmd_mis_addr   (cmd_mis_addr),
    .sfm_smc_hsel   (hsel),
    .sfm_smc_haddr  (haddr),
    .sfm_smc_htrans (htrans),
    .sfm_smc_hwrite (hwrite),
    .sfm_smc_hsize  (hsize),
    .sfm_smc_hprot  (hprot),
    .sfm_smc_hwdata (hwdata),
    .smc_sfm_hrdata (hrdata),
    .smc_sfm_hready (hready),
    .smc_sfm_hresp  (hresp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        wr;
  } a_t;

  typedef struct {
    int          cyc;
    logic        err;
    logic [15:0] mis;
    logic [31:0] maddr;
  } r_t;

  a_t          aq[$];
  logic [31:0] wq[$];
  r_t          rq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event not expected at cycle %0d", nm, cyc);
  endtask

  task automatic push_a(input logic [31:0] a, input logic [1:0] t,
                        input logic w);
    a_t e;
    e.addr = a; e.trans = t; e.wr = w;
    aq.push_back(e);
  endtask

  // slave model: stalls, two-cycle error, corrupted read beat
  int          s_stall_beat = -1, s_stall_n = 0;
  int          s_err_beat = -1, s_bad_beat = -1, s_err_ph = 0;
  logic [31:0] s_base = '0, s_pat = '0, s_bad = '0;
  logic        s_incr = 1'b0;
  logic        s_dp = 1'b0;
  int          s_beat = 0;

  task automatic slave_cfg(input logic [31:0] base, pat,
                           input logic incr, input int stb, stn,
                           input int eb, bb, input logic [31:0] bv);
    s_base = base; s_pat = pat; s_incr = incr;
    s_stall_beat = stb; s_stall_n = stn;
    s_err_beat = eb; s_err_ph = 0;
    s_bad_beat = bb; s_bad = bv;
  endtask

  always @(negedge clk) begin
    hready = 1'b1;
    hresp  = 2'b00;
    hrdata = '0;
    if (!rst_n) begin
      s_dp = 1'b0;
    end else begin
      if (s_dp) begin
        if (s_beat == s_err_beat) begin
          hresp = 2'b01;
          if (s_err_ph == 0) begin
            hready = 1'b0;
            s_err_ph = 1;
          end
        end else if (s_beat == s_stall_beat && s_stall_n > 0) begin
          hready = 1'b0;
          s_stall_n--;
        end else if (s_beat == s_bad_beat) begin
          hrdata = s_bad;
        end else begin
          hrdata = s_pat + (s_incr ? 32'(s_beat) : 32'd0);
        end
      end
      if (hready) begin
        s_dp   = htrans[1];
        s_beat = int'((haddr - s_base) >> 2);
      end
    end
  end

  // scoreboard monitor
  logic m_dp = 1'b0, m_wr = 1'b0;
  int   done_cnt = 0;
  r_t   cur;

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      m_dp = 1'b0;
    end else begin
      if (htrans != 2'b00) begin
        if (aq.size() != 0) begin
          chk("haddr", haddr, aq[0].addr);
          chk("htrans", 32'(htrans), 32'(aq[0].trans));
          chk("hwrite", 32'(hwrite), 32'(aq[0].wr));
          chk("hsel", 32'(hsel), 32'd1);
          chk("hsize_hprot", 32'({hsize, hprot}), 32'h23);
          if (hready) void'(aq.pop_front());
        end else if (hready) begin
          fail("addr_unexp");
        end
      end
      if (m_dp && m_wr) begin
        if (wq.size() != 0) begin
          chk("hwdata", hwdata, wq[0]);
          if (hready) void'(wq.pop_front());
        end else begin
          fail("wdata_unexp");
        end
      end
      if (hready) begin
        m_dp = htrans[1];
        m_wr = hwrite;
      end
      if (cmd_done) begin
        done_cnt++;
        if (rq.size() != 0) begin
          cur = rq.pop_front();
          chk("done_cycle", 32'(cyc), 32'(cur.cyc));
          chk("cmd_err", 32'(cmd_err), 32'(cur.err));
          chk("mis_cnt", 32'(cmd_mis_cnt), 32'(cur.mis));
          chk("mis_addr", cmd_mis_addr, cur.maddr);
          chk("busy_at_done", 32'(cmd_busy), 32'd1);
        end else begin
          fail("done_unexp");
        end
      end
    end
  end

  // off < 0: no completion expected
  task automatic run(input logic wr, incr, input logic [31:0] addr,
                     input logic [15:0] len, input logic [31:0] pat,
                     input int off, input logic err,
                     input logic [15:0] mis, input logic [31:0] maddr);
    r_t r;
    @(negedge clk);
    cmd_write = wr; cmd_incr = incr; cmd_addr = addr;
    cmd_len = len; cmd_pattern = pat; cmd_start = 1'b1;
    if (off >= 0) begin
      r.cyc = cyc + 1 + off; r.err = err;
      r.mis = mis; r.maddr = maddr;
      rq.push_back(r);
    end
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input int n0);
    int i;
    i = 0;
    while (done_cnt == n0 && i < 40) begin
      @(negedge clk); #2;
      i++;
    end
    if (done_cnt == n0) fail("done_timeout");
    repeat (2) @(negedge clk);
    chk("aq_left", 32'(aq.size()), 32'd0);
    chk("wq_left", 32'(wq.size()), 32'd0);
    chk("rq_left", 32'(rq.size()), 32'd0);
  endtask

  task automatic rst_chk();
    chk("rst_htrans", 32'(htrans), 32'd0);
    chk("rst_hsel", 32'(hsel), 32'd0);
    chk("rst_haddr", haddr, 32'd0);
    chk("rst_hwrite", 32'(hwrite), 32'd0);
    chk("rst_hwdata", hwdata, 32'd0);
    chk("rst_busy", 32'(cmd_busy), 32'd0);
    chk("rst_done", 32'(cmd_done), 32'd0);
    chk("rst_err", 32'(cmd_err), 32'd0);
    chk("rst_mis_cnt", 32'(cmd_mis_cnt), 32'd0);
    chk("rst_mis_addr", cmd_mis_addr, 32'd0);
  endtask

  int n0;

  initial begin
    repeat (3) @(negedge clk);
    #1 rst_chk();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // write, zero wait states
    slave_cfg(32'h2000_0000, 0, 0, -1, 0, -1, -1, 0);
    push_a(32'h2000_0000, 2'b10, 1); push_a(32'h2000_0004, 2'b11, 1);
    push_a(32'h2000_0008, 2'b11, 1); push_a(32'h2000_000C, 2'b11, 1);
    wq.push_back(32'hA5A5_0000); wq.push_back(32'hA5A5_0001);
    wq.push_back(32'hA5A5_0002); wq.push_back(32'hA5A5_0003);
    n0 = done_cnt;
    run(1, 1, 32'h2000_0000, 4, 32'hA5A5_0000, 5, 0, 0, 0);
    wait_done(n0);

    // write, two wait states on beat 1 data phase
    slave_cfg(32'h2000_0000, 0, 0, 1, 2, -1, -1, 0);
    push_a(32'h2000_0000, 2'b10, 1); push_a(32'h2000_0004, 2'b11, 1);
    push_a(32'h2000_0008, 2'b11, 1); push_a(32'h2000_000C, 2'b11, 1);
    wq.push_back(32'hA5A5_0000); wq.push_back(32'hA5A5_0001);
    wq.push_back(32'hA5A5_0002); wq.push_back(32'hA5A5_0003);
    n0 = done_cnt;
    run(1, 1, 32'h2000_0000, 4, 32'hA5A5_0000, 7, 0, 0, 0);
    wait_done(n0);

    // read compare, beat 2 corrupted
    slave_cfg(32'h3000_0000, 32'h1234_5678, 0, -1, 0, -1, 2,
              32'hDEAD_BEEF);
    push_a(32'h3000_0000, 2'b10, 0); push_a(32'h3000_0004, 2'b11, 0);
    push_a(32'h3000_0008, 2'b11, 0); push_a(32'h3000_000C, 2'b11, 0);
    n0 = done_cnt;
    run(0, 0, 32'h3000_0000, 4, 32'h1234_5678, 5, 0, 1,
        32'h3000_0008);
    wait_done(n0);

    // ERROR response on beat 1; beats 2 and 3 never accepted
    slave_cfg(32'h2000_0000, 0, 0, -1, 0, 1, -1, 0);
    push_a(32'h2000_0000, 2'b10, 1); push_a(32'h2000_0004, 2'b11, 1);
    wq.push_back(32'h55AA_0000); wq.push_back(32'h55AA_0001);
    n0 = done_cnt;
    run(1, 1, 32'h2000_0000, 4, 32'h55AA_0000, 4, 1, 0, 0);
    wait_done(n0);

    // boundary crossing plus a start while busy
    slave_cfg(32'h0000_03FC, 0, 0, -1, 0, -1, -1, 0);
    push_a(32'h0000_03FC, 2'b10, 1); push_a(32'h0000_0400, 2'b10, 1);
    wq.push_back(32'hCAFE_F00D); wq.push_back(32'hCAFE_F00D);
    n0 = done_cnt;
    run(1, 0, 32'h0000_03FE, 2, 32'hCAFE_F00D, 3, 0, 0, 0);
    cmd_addr = 32'h0000_5000; cmd_len = 16'd1; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    wait_done(n0);

    // zero length
    n0 = done_cnt;
    run(1, 1, 32'h1000_0000, 0, 32'h0, 0, 0, 0, 0);
    wait_done(n0);

    // reset during beat 2
    slave_cfg(32'h2000_0000, 0, 0, -1, 0, -1, -1, 0);
    push_a(32'h2000_0000, 2'b10, 1); push_a(32'h2000_0004, 2'b11, 1);
    push_a(32'h2000_0008, 2'b11, 1); push_a(32'h2000_000C, 2'b11, 1);
    wq.push_back(32'h0000_0000); wq.push_back(32'h0000_0001);
    wq.push_back(32'h0000_0002); wq.push_back(32'h0000_0003);
    run(1, 1, 32'h2000_0000, 4, 32'h0, -1, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1 rst_chk();
    aq.delete(); wq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // post-reset read with address wrap
    slave_cfg(32'hFFFF_FFF8, 32'h0000_0100, 1, -1, 0, -1, -1, 0);
    push_a(32'hFFFF_FFF8, 2'b10, 0); push_a(32'hFFFF_FFFC, 2'b11, 0);
    push_a(32'h0000_0000, 2'b10, 0);
    n0 = done_cnt;
    run(0, 1, 32'hFFFF_FFF8, 3, 32'h0000_0100, 4, 0, 0, 0);
    wait_done(n0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/smc_ahb_fill_master.md
Name: smc_ahb_fill_master

Overview:
- Command-driven AHB-Lite initiator that fills or verifies a region of SMC/ISMC SRAM through one hmain0-style slave port.
- It is the initiator counterpart of the SMC slave ports. Boot/PMU firmware or the scrub controller uses it for memory init, BIST-lite pattern checks and post-retention scrubbing.
- It issues pipelined single-word transfers, handles wait states and two-cycle ERROR responses, and reports results.

Parameters:
- LEN_W, 16, width of word count and mismatch counter
- HPROT_VAL, 4'b0011, constant hprot driven on every transfer (data, privileged)
- BOUND_BYTES, 1024, address boundary at which a sequential beat restarts with NONSEQ

Ports:
- pmu_smc_hclk  in  1  AHB clock
- pmu_smc_hrst_b  in  1  asynchronous active-low reset
- cmd_start  in  1  start pulse; sampled only when cmd_busy=0
- cmd_write  in  1  1 = fill (write), 0 = read-compare
- cmd_incr  in  1  1 = expected/written data is cmd_pattern+beat index; 0 = constant cmd_pattern
- cmd_addr  in  32  byte base address; bits [1:0] forced to 0
- cmd_len  in  LEN_W  number of 32-bit words
- cmd_pattern  in  32  data seed
- cmd_busy  out  1  command in progress
- cmd_done  out  1  one-cycle completion pulse
- cmd_err  out  1  command terminated by an ERROR response
- cmd_mis_cnt  out  LEN_W  read mismatches, saturating
- cmd_mis_addr  out  32  address of the first mismatch
- sfm_smc_hsel  out  1  slave select
- sfm_smc_haddr  out  32  address
- sfm_smc_htrans  out  2  IDLE=00, NONSEQ=10, SEQ=11
- sfm_smc_hwrite  out  1  write flag
- sfm_smc_hsize  out  3  always 3'b010
- sfm_smc_hprot  out  4  HPROT_VAL
- sfm_smc_hwdata  out  32  write data
- smc_sfm_hrdata  in  32  read data
- smc_sfm_hready  in  1  transfer-done/ready
- smc_sfm_hresp  in  2  00 OKAY, 01 ERROR

Behaviour:
- Reset (asynchronous, immediate):
  - state IDLE; htrans=00, hsel=0, haddr=0, hwrite=0, hwdata=0.
  - cmd_busy=0, cmd_done=0, cmd_err=0, cmd_mis_cnt=0, cmd_mis_addr=0.
  - Reset mid-command abandons the command; no done pulse is produced.
- States: IDLE, ADDR (address phases issuing), DRAIN (final data phase pending), ERR (second error cycle), DONE (pulse cycle).
- IDLE:
  - cmd_start=1 latches all cmd_* inputs and clears cmd_err, cmd_mis_cnt and cmd_mis_addr.
  - len=0: go to DONE; no bus activity.
  - Otherwise go to ADDR; beat 0 address phase appears the next cycle.
- cmd_start while cmd_busy=1 is ignored.
- cmd_busy=1 in every state except IDLE. hsel=cmd_busy.
- ADDR:
  - Drives beat i address = base+4i.
  - htrans=NONSEQ for beat 0 and for any beat whose address is a multiple of BOUND_BYTES; SEQ otherwise.
  - Address advances only on a cycle with hready=1.
  - After the last address is accepted: htrans=IDLE, go to DRAIN.
- Data phase of beat i is the cycle(s) after its address acceptance:
  - hwdata = expected(i), held until hready=1.
  - expected(i) = cmd_incr ? pattern+i (mod 2^32) : pattern.
- All master outputs hold stable while hready=0, except the ERROR rule below.
- Read compare is evaluated on data-phase completion (hready=1, hresp=OKAY):
  - If hrdata≠expected(i), cmd_mis_cnt increments, saturating at all-ones.
  - cmd_mis_addr captures the beat address on the first mismatch only.
- ERROR handling:
  - hresp=01 with hready=0 in any data phase: next cycle htrans=IDLE, which cancels any pending address phase; go to ERR.
  - hresp=01 with hready=1: set cmd_err=1 and go to DONE. No further beats are issued.
- DRAIN: on final data-phase completion go to DONE.
- DONE: cmd_done=1 for exactly one cycle, then IDLE.
- Results hold until the next accepted start.
- Timing with zero wait states: start sampled at edge N, first NONSEQ in cycle N+1, cmd_done in cycle N+len+2.
- Beat and address counters are LEN_W and 32 bits. Addresses wrap modulo 2^32 without error.

Test Plan:
- Write, zero wait: addr=0x2000_0000, len=4, pattern=0xA5A5_0000, incr=1, hready=1.
  - htrans 10,11,11,11 in cycles 1-4; haddr 0x..00/04/08/0C.
  - hwdata 0xA5A50000..03 in cycles 2-5.
  - cmd_done in cycle 6; cmd_err=0.
- Wait states: as above with hready=0 for 2 cycles during the beat-1 data phase.
  - haddr=0x2000_0008/htrans=11 and hwdata=0xA5A50001 held stable; done delayed by 2 cycles (cycle 8).
- Read compare: len=4, pattern=0x1234_5678, incr=0; beat 2 returns 0xDEADBEEF.
  - cmd_mis_cnt=1, cmd_mis_addr=base+8, cmd_err=0.
- Error: beat 1 data phase returns hresp=01/hready=0, then 01/hready=1.
  - htrans=00 in the second error cycle; no beat-3 address issued.
  - cmd_err=1; cmd_done pulses next cycle.
- Boundary and zero-length:
  - addr=0x0000_03FC, len=2 -> NONSEQ@0x3FC then NONSEQ@0x400.
  - len=0 -> done in cycle N+1 with htrans=00 throughout.
  - cmd_start while busy is ignored.
- Reset mid-command: assert pmu_smc_hrst_b=0 during beat 2.
  - All outputs return to reset values in the same cycle; no cmd_done pulse.
  - A new command after release runs normally.
